// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared state type and default sizing for the SPI slave
package spi_pkg;
    localparam int SPI_DATA_W      = 8;
    localparam int SPI_SYNC_STAGES = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } spi_state_e;
endpackage

// File: rtl/spi_slave_if.sv
// rtl/spi_slave_if.sv - SPI pins, mode straps and tx/rx handshake for the SPI slave
interface spi_slave_if import spi_pkg::*; #(
    parameter int DATA_W = SPI_DATA_W
);
    logic              sclk;
    logic              mosi;
    logic              cs_n;
    logic              miso;
    logic              cpol;
    logic              cpha;
    logic [DATA_W-1:0] tx_data;
    logic              tx_load;
    logic              tx_ready;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              tx_underrun;
    logic              busy;

    modport slave (
        input  sclk, mosi, cs_n, cpol, cpha, tx_data, tx_load,
        output miso, tx_ready, rx_data, rx_valid, tx_underrun, busy
    );

    modport master (
        output sclk, mosi, cs_n, cpol, cpha, tx_data, tx_load,
        input  miso, tx_ready, rx_data, rx_valid, tx_underrun, busy
    );
endinterface

// File: rtl/spi_edge_sync.sv
// rtl/spi_edge_sync.sv - multi-flop synchronizer with rise/fall pulse detection
module spi_edge_sync import spi_pkg::*; #(
    parameter int SYNC_STAGES = SPI_SYNC_STAGES
) (
    input  logic clk,
    input  logic reset,
    input  logic rst_val_i,
    input  logic din_i,
    output logic rise_o,
    output logic fall_o
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   level;

    assign level = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= {SYNC_STAGES{rst_val_i}};
            prev_q <= rst_val_i;
        end else begin
            sync_q[0] <= din_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= level;
        end
    end

    assign rise_o = level & ~prev_q;
    assign fall_o = ~level & prev_q;
endmodule

// File: rtl/spi_slave.sv
// rtl/spi_slave.sv - SPI slave, modes 0-3, one-entry tx buffer, MSB first
// Define SPI_SLAVE_MISO_TRISTATE_EN to float miso while idle or in reset.
module spi_slave import spi_pkg::*; #(
    parameter int DATA_W      = SPI_DATA_W,
    parameter int SYNC_STAGES = SPI_SYNC_STAGES
) (
    input  logic       clk,
    input  logic       reset,
    spi_slave_if.slave bus
);
    localparam int                CNT_W    = (DATA_W > 2) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    logic sclk_rise, sclk_fall, cs_rise, cs_fall;
    logic [SYNC_STAGES-1:0] mosi_sync_q;

    spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sclk_sync (
        .clk       (clk),
        .reset     (reset),
        .rst_val_i (bus.cpol),
        .din_i     (bus.sclk),
        .rise_o    (sclk_rise),
        .fall_o    (sclk_fall)
    );

    spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_cs_sync (
        .clk       (clk),
        .reset     (reset),
        .rst_val_i (1'b1),
        .din_i     (bus.cs_n),
        .rise_o    (cs_rise),
        .fall_o    (cs_fall)
    );

    // mosi uses the same depth as sclk so a sample edge sees the bit the master set up
    always_ff @(posedge clk) begin
        if (reset) begin
            mosi_sync_q <= '0;
        end else begin
            mosi_sync_q[0] <= bus.mosi;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                mosi_sync_q[i] <= mosi_sync_q[i-1];
            end
        end
    end

    spi_state_e        state_q;
    logic [DATA_W-1:0] tx_sr_q;
    logic [DATA_W-2:0] rx_sr_q;
    logic [DATA_W-1:0] rx_sr_d;
    logic [DATA_W-1:0] rx_data_q;
    logic [DATA_W-1:0] tx_buf_q;
    logic [CNT_W-1:0]  bit_cnt_q;
    logic              tx_empty_q;
    logic              skip_q;
    logic              ur_pend_q;
    logic              rx_valid_q;
    logic              tx_underrun_q;

    logic leading, trailing, sample_edge, shift_edge;
    logic start, last_sample, load_pt, direct_load;

    assign leading     = bus.cpol ? sclk_fall : sclk_rise;
    assign trailing    = bus.cpol ? sclk_rise : sclk_fall;
    assign sample_edge = bus.cpha ? trailing : leading;
    assign shift_edge  = bus.cpha ? leading : trailing;
    assign rx_sr_d     = {rx_sr_q, mosi_sync_q[SYNC_STAGES-1]};

    assign start       = (state_q == IDLE) && cs_fall;
    assign last_sample = (state_q == SHIFT) && !cs_rise && sample_edge && (bit_cnt_q == LAST_BIT);
    assign load_pt     = start || last_sample;
    assign direct_load = bus.tx_load && tx_empty_q;

    // After any load the next shift edge must leave the fresh MSB on miso, hence skip_q.
    // An underrun is reported once the zero byte actually starts to be clocked.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            tx_sr_q       <= '0;
            rx_sr_q       <= '0;
            rx_data_q     <= '0;
            tx_buf_q      <= '0;
            bit_cnt_q     <= '0;
            tx_empty_q    <= 1'b1;
            skip_q        <= 1'b0;
            ur_pend_q     <= 1'b0;
            rx_valid_q    <= 1'b0;
            tx_underrun_q <= 1'b0;
        end else begin
            rx_valid_q    <= 1'b0;
            tx_underrun_q <= 1'b0;
            if (direct_load) begin
                tx_buf_q   <= bus.tx_data;
                tx_empty_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (cs_fall) begin
                        state_q   <= SHIFT;
                        bit_cnt_q <= '0;
                        skip_q    <= bus.cpha;
                        ur_pend_q <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (cs_rise) begin
                        state_q   <= IDLE;
                        ur_pend_q <= 1'b0;
                    end else if (sample_edge) begin
                        rx_sr_q <= rx_sr_d[DATA_W-2:0];
                        if (ur_pend_q) begin
                            tx_underrun_q <= 1'b1;
                            ur_pend_q     <= 1'b0;
                        end
                        if (bit_cnt_q == LAST_BIT) begin
                            rx_data_q  <= rx_sr_d;
                            rx_valid_q <= 1'b1;
                            bit_cnt_q  <= '0;
                            skip_q     <= 1'b1;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                        end
                    end else if (shift_edge) begin
                        if (skip_q) begin
                            skip_q <= 1'b0;
                        end else begin
                            tx_sr_q <= tx_sr_q << 1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
            if (load_pt) begin
                if (direct_load) begin
                    tx_sr_q    <= bus.tx_data;
                    tx_empty_q <= 1'b1;
                end else if (!tx_empty_q) begin
                    tx_sr_q    <= tx_buf_q;
                    tx_empty_q <= 1'b1;
                end else begin
                    tx_sr_q   <= '0;
                    ur_pend_q <= 1'b1;
                end
            end
        end
    end

    logic miso_en;
    assign miso_en = (state_q == SHIFT) && !reset;

`ifdef SPI_SLAVE_MISO_TRISTATE_EN
    assign bus.miso = miso_en ? tx_sr_q[DATA_W-1] : 1'bz;
`else
    assign bus.miso = miso_en & tx_sr_q[DATA_W-1];
`endif

    assign bus.rx_data     = rx_data_q;
    assign bus.rx_valid    = rx_valid_q;
    assign bus.tx_underrun = tx_underrun_q;
    assign bus.tx_ready    = tx_empty_q;
    assign bus.busy        = (state_q == SHIFT);
endmodule

// File: tb/tb_spi_slave.sv
// tb/tb_spi_slave.sv - directed self-checking bench for spi_slave
module tb_spi_slave;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    spi_slave_if #(.DATA_W(8)) bus ();

    spi_slave #(.DATA_W(8), .SYNC_STAGES(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int rxv_cnt = 0;
    int ur_cnt = 0;
    int rx_base, ur_base;
    logic [7:0] rx_hist [0:15];
    logic [7:0] mosi_bytes [0:3];
    logic [7:0] miso_bytes [0:3];
    logic [7:0] mode_tx [1:3];
    logic [7:0] bnd_data;
    bit         bnd_load;
    logic       miso_idle;

    always @(negedge clk) begin
        if (bus.rx_valid === 1'b1) begin
            rx_hist[rxv_cnt % 16] = bus.rx_data;
            rxv_cnt++;
        end
        if (bus.tx_underrun === 1'b1) ur_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load_tx(input logic [7:0] d);
        @(negedge clk);
        bus.tx_data = d;
        bus.tx_load = 1'b1;
        @(negedge clk);
        bus.tx_load = 1'b0;
    endtask

    task automatic set_mode(input logic pol, input logic pha);
        bus.cpol = pol;
        bus.cpha = pha;
        bus.sclk = pol;
        wait_clk(8);
    endtask

    // sclk half period is four clk cycles; tx_load at the boundary lands on the load cycle
    task automatic spi_run(input int nbits, input bit end_cs);
        bus.cs_n = 1'b0;
        wait_clk(8);
        chk("busy_in_frame", bus.busy, 1);
        for (int b = 0; b < nbits; b++) begin
            int byte_i = b / 8;
            int bit_i  = 7 - (b % 8);
            if (bus.cpha == 1'b0) begin
                bus.mosi = mosi_bytes[byte_i][bit_i];
                wait_clk(4);
                miso_bytes[byte_i][bit_i] = bus.miso;
                bus.sclk = ~bus.cpol;
                if (bnd_load && b == 7) begin
                    wait_clk(2);
                    bus.tx_data = bnd_data;
                    bus.tx_load = 1'b1;
                    wait_clk(1);
                    bus.tx_load = 1'b0;
                    wait_clk(1);
                end else begin
                    wait_clk(4);
                end
                bus.sclk = bus.cpol;
            end else begin
                bus.sclk = ~bus.cpol;
                bus.mosi = mosi_bytes[byte_i][bit_i];
                wait_clk(4);
                miso_bytes[byte_i][bit_i] = bus.miso;
                bus.sclk = bus.cpol;
                wait_clk(4);
            end
        end
        wait_clk(4);
        if (end_cs) begin
            bus.cs_n = 1'b1;
            wait_clk(8);
        end
    endtask

    initial begin
`ifdef SPI_SLAVE_MISO_TRISTATE_EN
        miso_idle = 1'bz;
`else
        miso_idle = 1'b0;
`endif
        mode_tx[1] = 8'h96;
        mode_tx[2] = 8'h3C;
        mode_tx[3] = 8'hE7;
        bnd_load = 1'b0;
        bnd_data = 8'h00;
        reset = 1'b1;
        bus.cs_n = 1'b1;
        bus.sclk = 1'b0;
        bus.mosi = 1'b0;
        bus.cpol = 1'b0;
        bus.cpha = 1'b0;
        bus.tx_data = 8'h00;
        bus.tx_load = 1'b0;
        wait_clk(3);
        chk("rst_rx_data", bus.rx_data, 8'h00);
        chk("rst_rx_valid", bus.rx_valid, 0);
        chk("rst_underrun", bus.tx_underrun, 0);
        chk("rst_tx_ready", bus.tx_ready, 1);
        chk("rst_busy", bus.busy, 0);
        chk("rst_miso", bus.miso, miso_idle);
        reset = 1'b0;
        wait_clk(4);

        // mode 0, plus a tx_load against a full buffer that must be dropped
        load_tx(8'hA5);
        chk("m0_tx_ready_full", bus.tx_ready, 0);
        load_tx(8'hFF);
        rx_base = rxv_cnt;
        ur_base = ur_cnt;
        mosi_bytes[0] = 8'h3C;
        spi_run(8, 1);
        chk("m0_rx_data", bus.rx_data, 8'h3C);
        chk("m0_rx_count", rxv_cnt - rx_base, 1);
        chk("m0_miso", miso_bytes[0], 8'hA5);
        chk("m0_underrun", ur_cnt - ur_base, 0);
        chk("m0_tx_ready", bus.tx_ready, 1);
        chk("m0_idle_miso", bus.miso, miso_idle);

        for (int m = 1; m <= 3; m++) begin
            set_mode(m >= 2, m % 2 == 1);
            load_tx(mode_tx[m]);
            rx_base = rxv_cnt;
            mosi_bytes[0] = 8'h81;
            spi_run(8, 1);
            chk($sformatf("mode%0d_rx_data", m), bus.rx_data, 8'h81);
            chk($sformatf("mode%0d_rx_count", m), rxv_cnt - rx_base, 1);
            chk($sformatf("mode%0d_miso", m), miso_bytes[0], mode_tx[m]);
        end
        set_mode(1'b0, 1'b0);

        // three-byte frame with a single byte buffered
        load_tx(8'h11);
        rx_base = rxv_cnt;
        ur_base = ur_cnt;
        mosi_bytes[0] = 8'h01;
        mosi_bytes[1] = 8'h02;
        mosi_bytes[2] = 8'h03;
        spi_run(24, 1);
        chk("mb_rx_count", rxv_cnt - rx_base, 3);
        chk("mb_rx0", rx_hist[(rx_base + 0) % 16], 8'h01);
        chk("mb_rx1", rx_hist[(rx_base + 1) % 16], 8'h02);
        chk("mb_rx2", rx_hist[(rx_base + 2) % 16], 8'h03);
        chk("mb_miso0", miso_bytes[0], 8'h11);
        chk("mb_miso1", miso_bytes[1], 8'h00);
        chk("mb_miso2", miso_bytes[2], 8'h00);
        chk("mb_underrun", ur_cnt - ur_base, 2);

        // cs_n rises after five bits
        load_tx(8'hC3);
        rx_base = rxv_cnt;
        ur_base = ur_cnt;
        mosi_bytes[0] = 8'hFF;
        spi_run(5, 1);
        chk("ab_rx_count", rxv_cnt - rx_base, 0);
        chk("ab_underrun", ur_cnt - ur_base, 0);
        chk("ab_busy", bus.busy, 0);
        load_tx(8'hBD);
        mosi_bytes[0] = 8'h7E;
        spi_run(8, 1);
        chk("ab_next_rx_data", bus.rx_data, 8'h7E);
        chk("ab_next_rx_count", rxv_cnt - rx_base, 1);
        chk("ab_next_miso", miso_bytes[0], 8'hBD);

        // tx_load landing exactly on the byte boundary
        load_tx(8'h24);
        rx_base = rxv_cnt;
        ur_base = ur_cnt;
        bnd_load = 1'b1;
        bnd_data = 8'h5A;
        mosi_bytes[0] = 8'h12;
        mosi_bytes[1] = 8'h34;
        spi_run(16, 1);
        bnd_load = 1'b0;
        chk("bnd_miso0", miso_bytes[0], 8'h24);
        chk("bnd_miso1", miso_bytes[1], 8'h5A);
        chk("bnd_underrun", ur_cnt - ur_base, 0);
        chk("bnd_tx_ready", bus.tx_ready, 1);
        chk("bnd_rx_count", rxv_cnt - rx_base, 2);

        // reset in the middle of a byte
        load_tx(8'h99);
        rx_base = rxv_cnt;
        mosi_bytes[0] = 8'h55;
        spi_run(3, 0);
        load_tx(8'h77);
        chk("mid_tx_ready_full", bus.tx_ready, 0);
        reset = 1'b1;
        bus.cs_n = 1'b1;
        bus.sclk = bus.cpol;
        wait_clk(1);
        chk("mid_rst_rx_valid", bus.rx_valid, 0);
        chk("mid_rst_underrun", bus.tx_underrun, 0);
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_tx_ready", bus.tx_ready, 1);
        chk("mid_rst_rx_data", bus.rx_data, 8'h00);
        chk("mid_rst_miso", bus.miso, miso_idle);
        wait_clk(2);
        reset = 1'b0;
        wait_clk(8);
        chk("mid_rst_no_rx", rxv_cnt - rx_base, 0);
        load_tx(8'h42);
        mosi_bytes[0] = 8'hC9;
        spi_run(8, 1);
        chk("post_rst_rx_data", bus.rx_data, 8'hC9);
        chk("post_rst_miso", miso_bytes[0], 8'h42);
        chk("post_rst_rx_count", rxv_cnt - rx_base, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
